mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-ported main memory between the instruction-fetch port (IR load, MOC) and the
//   data port (MDR load/store, DMOC) of the multicycle datapath. It grants one port at a time,
//   counts out a fixed memory latency and returns a 4-phase MOV/MOC handshake per port. It sits
//   between the DataPath memory signals and the RAM model.
// PARAMETERS
//   ADDR_W   9   memory byte-address width
//   MEM_LAT  2   cycles mem_en is held per access; legal range 1..15
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       synchronous, active-high reset
//   i_mov      in   1       fetch request; level, held until i_moc seen
//   i_addr     in   ADDR_W  fetch byte address (word access)
//   i_moc      out  1       fetch complete; i_rdata valid while high
//   i_rdata    out  32      fetched word
//   d_mov      in   1       data request; level, held until d_moc seen
//   d_rw       in   1       1 = read, 0 = write
//   d_size     in   2       00 byte, 01 halfword, 10 word (11 treated as word)
//   d_addr     in   ADDR_W  data byte address
//   d_wdata    in   32      store data, already lane-aligned by datapath
//   d_moc      out  1       data access complete; d_rdata valid while high on reads
//   d_rdata    out  32      raw read word (extension done in datapath)
//   mem_en     out  1       RAM access strobe
//   mem_rw     out  1       1 = read, 0 = write
//   mem_be     out  4       byte enables, big-endian: be[3] = bits 31:24 = byte addr[1:0]=00
//   mem_addr   out  ADDR_W  word-aligned address (addr[1:0] forced 00)
//   mem_wdata  out  32      store data
//   mem_rdata  in   32      RAM read data, valid in last access cycle
//   arb_state  out  3       current state encoding, test visibility
// BEHAVIOUR
//   States: IDLE=0, I_ACC=1, D_ACC=2, I_DONE=3, D_DONE=4; other codes -> IDLE next cycle.
//   Reset: state IDLE, all outputs 0, i_rdata/d_rdata 0, last_grant=D (so I wins first tie).
//   IDLE: sample i_mov/d_mov. One high -> grant it. Both high -> grant port != last_grant.
//     Grant latches addr/rw/size/wdata into request regs, loads cnt=MEM_LAT-1, updates last_grant.
//   I_ACC/D_ACC: mem_en=1 with latched request; port inputs ignored. cnt decrements each cycle.
//     At cnt==0: capture mem_rdata into the granted port's rdata if read; go to x_DONE if that
//     port's mov is still high, else IDLE (abort: access still completes, no moc).
//   x_DONE: x_moc=1 (registered), mem_en=0; stay while x_mov high; on x_mov low -> IDLE, moc drops
//     the same edge. The other port's request waits; it is never lost.
//   Latency: mov high sampled at edge k -> mem_en high k+1..k+MEM_LAT -> moc high from edge k+MEM_LAT+1.
//   Turnaround: at least one IDLE cycle between grants; back-to-back ties alternate I/D.
//   I port: mem_rw=1, mem_be=1111 always.
//   D port byte enables: word 1111; half addr[1]=0 -> 1100, addr[1]=1 -> 0011 (addr[0] ignored);
//     byte addr[1:0]=00/01/10/11 -> 1000/0100/0010/0001. Reads also drive be; RAM returns full word.
//   rdata regs hold their value until the next completed read on the same port.
//   Reset mid-access: IDLE next edge, mem_en low, moc low, no rdata update; partial write acceptable.
//   Outputs mem_* driven 0 when mem_en=0.
// TESTING
//   1 reset, i_mov=1 addr 0x010, MEM_LAT=2, RAM word 0x8C220004 -> mem_en cycles 1-2, i_moc at
//     cycle 3, i_rdata=0x8C220004; drop i_mov -> i_moc 0, state IDLE next cycle.
//   2 i_mov and d_mov rise together after reset -> I served first, D granted in the cycle after
//     I_DONE exits; next tie -> D served first.
//   3 d_rw=0, size byte, addr 0x0F3, wdata 0x000000AB -> mem_addr 0x0F0, mem_be 0001, mem_rw 0,
//     d_moc after MEM_LAT+1; halfword addr 0x0F2 -> be 0011.
//   4 d_mov dropped during D_ACC -> access finishes MEM_LAT cycles, d_moc never asserts, IDLE.
//   5 reset asserted in I_ACC cycle 1 -> next edge state 0, mem_en 0, i_moc 0, i_rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported RAM between the instruction-fetch
//             port and the data port. One port is granted at a time. The
//             access is held for MEM_LAT cycles, and each port gets a
//             4-phase MOV/MOC handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mov,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_moc,
  output logic [31:0]       i_rdata,
  input  logic              d_mov,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_moc,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        arb_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_ACC  = 3'd1,
    ST_D_ACC  = 3'd2,
    ST_I_DONE = 3'd3,
    ST_D_DONE = 3'd4
  } state_t;

  localparam logic              GNT_I     = 1'b0;
  localparam logic              GNT_D     = 1'b1;
  localparam logic [3:0]        CNT_INIT  = 4'(MEM_LAT - 1);
  // Clears the two lane bits so the RAM always sees a word address.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               load_i, load_d;
  logic [ADDR_W-1:0]  req_addr_q;
  logic               req_rw_q;
  logic [3:0]         req_be_q;
  logic [31:0]        req_wdata_q;
  logic [31:0]        i_rdata_q, d_rdata_q;
  logic [3:0]         d_be;

  // Big-endian byte lanes for the data port: be[3] is byte address 00.
  always_comb begin
    d_be = 4'b1111;
    case (d_size)
      2'b00: begin
        case (d_addr[1:0])
          2'b00:   d_be = 4'b1000;
          2'b01:   d_be = 4'b0100;
          2'b10:   d_be = 4'b0010;
          default: d_be = 4'b0001;
        endcase
      end
      2'b01:   d_be = d_addr[1] ? 4'b0011 : 4'b1100;
      default: d_be = 4'b1111;
    endcase
  end

  // Next-state logic. A tie goes to the port that was not granted last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    load_i  = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_mov && (!d_mov || last_q == GNT_D)) begin
          state_d = ST_I_ACC;
          load_i  = 1'b1;
          cnt_d   = CNT_INIT;
          last_d  = GNT_I;
        end else if (d_mov) begin
          state_d = ST_D_ACC;
          load_d  = 1'b1;
          cnt_d   = CNT_INIT;
          last_d  = GNT_D;
        end
      end
      ST_I_ACC: begin
        if (cnt_q == 4'd0) state_d = i_mov ? ST_I_DONE : ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_D_ACC: begin
        if (cnt_q == 4'd0) state_d = d_mov ? ST_D_DONE : ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_I_DONE: if (!i_mov) state_d = ST_IDLE;
      ST_D_DONE: if (!d_mov) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, counter and grant-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= GNT_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Latch the granted request so port inputs can change during the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_q  <= '0;
      req_rw_q    <= 1'b0;
      req_be_q    <= 4'b0000;
      req_wdata_q <= 32'd0;
    end else if (load_i) begin
      req_addr_q  <= i_addr;
      req_rw_q    <= 1'b1;
      req_be_q    <= 4'b1111;
      req_wdata_q <= 32'd0;
    end else if (load_d) begin
      req_addr_q  <= d_addr;
      req_rw_q    <= d_rw;
      req_be_q    <= d_be;
      req_wdata_q <= d_wdata;
    end
  end

  // Capture read data in the last access cycle. It is held until the next read on that port.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      if (state_q == ST_I_ACC && cnt_q == 4'd0)             i_rdata_q <= mem_rdata;
      if (state_q == ST_D_ACC && cnt_q == 4'd0 && req_rw_q) d_rdata_q <= mem_rdata;
    end
  end

  // Outputs decode from registered state. The memory bus is zero outside an access.
  always_comb begin
    mem_en    = (state_q == ST_I_ACC) || (state_q == ST_D_ACC);
    mem_rw    = mem_en ? req_rw_q : 1'b0;
    mem_be    = mem_en ? req_be_q : 4'b0000;
    mem_addr  = mem_en ? (req_addr_q & ADDR_MASK) : '0;
    mem_wdata = mem_en ? req_wdata_q : 32'd0;
    i_moc     = (state_q == ST_I_DONE);
    d_moc     = (state_q == ST_D_DONE);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    arb_state = state_q;
  end

endmodule
`default_nettype wire
